// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter stage.
// State encodings and the sequential PC increment.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
  } next_pc_t;

  function automatic logic is_misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit_sel.sv
// Next-PC target selection with fixed priority.
// Flags misaligned targets produced by taken redirects.
module next_pc_sel
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] target,
  output logic        misaligned
);

  next_pc_t sel;
  logic [31:0] jalr_sum;
  logic [31:0] rel_sum;

  assign jalr_sum = rs1 + imm;
  assign rel_sum  = pc + imm;

  always_comb begin
    sel = '{target: pc_plus4, redirect: 1'b0, misaligned: 1'b0};
    priority case (1'b1)
      jalr: begin
        sel.target   = jalr_sum & ~32'h1;
        sel.redirect = 1'b1;
      end
      jal: begin
        sel.target   = rel_sum;
        sel.redirect = 1'b1;
      end
      (branch && branch_taken): begin
        sel.target   = rel_sum;
        sel.redirect = 1'b1;
      end
      default: begin
        sel.target   = pc_plus4;
        sel.redirect = 1'b0;
      end
    endcase
    sel.misaligned = sel.redirect && is_misaligned(sel.target);
  end

  assign target     = sel.target;
  assign misaligned = sel.misaligned;

endmodule

// File: rtl/pc_unit.sv
// PC register, BOOT/RUN/TRAP sequencing, trap capture and
// retired-instruction counter feeding instruction fetch.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        BranchTaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        trap_valid,
  input  logic        trap_ack,
  output logic [31:0] epc,
  output logic [31:0] bad_addr,
  output logic [31:0] instret
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("pc_unit: RESET_PC must be 4-byte aligned");
  end
  if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
    $error("pc_unit: TRAP_VEC must be 4-byte aligned");
  end

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic [31:0] instret_q, instret_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        trap_valid_q, trap_valid_d;

  logic [31:0] target;
  logic        misaligned;

  assign pc_plus4 = pc_q + PC_STEP;

  next_pc_sel u_sel (
    .pc           (pc_q),
    .pc_plus4     (pc_plus4),
    .branch       (branch),
    .branch_taken (BranchTaken),
    .jal          (jal),
    .jalr         (jalr),
    .imm          (imm),
    .rs1          (rs1),
    .target       (target),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    bad_addr_d = bad_addr_q;
    instret_d  = instret_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (misaligned) begin
            epc_d      = pc_q;
            bad_addr_d = target;
            pc_d       = TRAP_VEC;
            state_d    = ST_TRAP;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 32'd1;
          end
        end
      end
      ST_TRAP: begin
        if (trap_ack) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
    // Valid flags are registered copies of the next state.
    fetch_valid_d = (state_d == ST_RUN);
    trap_valid_d  = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      epc_q         <= 32'd0;
      bad_addr_q    <= 32'd0;
      instret_q     <= 32'd0;
      fetch_valid_q <= 1'b0;
      trap_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      bad_addr_q    <= bad_addr_d;
      instret_q     <= instret_d;
      fetch_valid_q <= fetch_valid_d;
      trap_valid_q  <= trap_valid_d;
    end
  end

  assign pc          = pc_q;
  assign epc         = epc_q;
  assign bad_addr    = bad_addr_q;
  assign instret     = instret_q;
  assign fetch_valid = fetch_valid_q;
  assign trap_valid  = trap_valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, redirects,
// traps, stalls, wrap-around and asynchronous reset.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, BranchTaken;
  logic        jal, jalr, trap_ack;
  logic [31:0] imm, rs1;
  logic [31:0] pc, pc_plus4, epc, bad_addr, instret;
  logic        fetch_valid, trap_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch      (branch),
    .BranchTaken (BranchTaken),
    .jal         (jal),
    .jalr        (jalr),
    .imm         (imm),
    .rs1         (rs1),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .trap_valid  (trap_valid),
    .trap_ack    (trap_ack),
    .epc         (epc),
    .bad_addr    (bad_addr),
    .instret     (instret)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(
    input logic        b,
    input logic        bt,
    input logic        j,
    input logic        jr,
    input logic [31:0] im,
    input logic [31:0] r1
  );
    branch      = b;
    BranchTaken = bt;
    jal         = j;
    jalr        = jr;
    imm         = im;
    rs1         = r1;
  endtask

  task automatic run_chk(
    input string       tag,
    input logic [31:0] exp_pc,
    input logic [31:0] exp_ret
  );
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".ret"}, instret, exp_ret);
    chk({tag, ".fv"}, {31'd0, fetch_valid}, 32'd1);
    chk({tag, ".tv"}, {31'd0, trap_valid}, 32'd0);
  endtask

  task automatic trap_chk(
    input string       tag,
    input logic [31:0] exp_epc,
    input logic [31:0] exp_bad,
    input logic [31:0] exp_ret
  );
    chk({tag, ".pc"}, pc, 32'h100);
    chk({tag, ".epc"}, epc, exp_epc);
    chk({tag, ".bad"}, bad_addr, exp_bad);
    chk({tag, ".ret"}, instret, exp_ret);
    chk({tag, ".fv"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, ".tv"}, {31'd0, trap_valid}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    trap_ack = 1'b0;
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    #12;
    chk("rst.pc", pc, 32'd0);
    chk("rst.fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst.tv", {31'd0, trap_valid}, 32'd0);
    chk("rst.epc", epc, 32'd0);
    chk("rst.bad", bad_addr, 32'd0);
    chk("rst.ret", instret, 32'd0);

    // release mid-cycle; BOOT must ignore stall
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall = 1'b1;
    chk("boot.pc", pc, 32'd0);
    chk("boot.fv", {31'd0, fetch_valid}, 32'd0);
    step();
    run_chk("run0", 32'd0, 32'd0);
    stall = 1'b0;
    step(); run_chk("seq4", 32'd4, 32'd1);
    chk("pc4", pc_plus4, 32'd8);
    step(); run_chk("seq8", 32'd8, 32'd2);
    step(); run_chk("seq12", 32'd12, 32'd3);

    flags(0, 0, 1, 0, 32'h14, 32'd0);
    step(); run_chk("to20", 32'h20, 32'd4);
    flags(1, 1, 0, 0, 32'hFFFF_FFF0, 32'd0);
    step(); run_chk("brT", 32'h10, 32'd5);
    flags(0, 0, 1, 0, 32'h10, 32'd0);
    step(); run_chk("back20", 32'h20, 32'd6);
    flags(1, 0, 0, 0, 32'hFFFF_FFF0, 32'd0);
    step(); run_chk("brNT", 32'h24, 32'd7);
    flags(0, 0, 1, 0, 32'hFFFF_FFFC, 32'd0);
    step(); run_chk("back20b", 32'h20, 32'd8);
    flags(0, 1, 0, 0, 32'hFFFF_FFF0, 32'd0);
    step(); run_chk("btNoBr", 32'h24, 32'd9);

    flags(0, 0, 1, 1, 32'h4, 32'h101);
    step(); run_chk("jalr", 32'h104, 32'd10);

    flags(0, 0, 1, 0, 32'hFFFF_FF3C, 32'd0);
    step(); run_chk("to40", 32'h40, 32'd11);
    flags(0, 0, 1, 0, 32'h6, 32'd0);
    step(); trap_chk("trap", 32'h40, 32'h46, 32'd11);

    // TRAP holds without ack; stall is ignored
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); trap_chk("hold", 32'h40, 32'h46, 32'd11);
    end
    stall    = 1'b0;
    trap_ack = 1'b1;
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    step(); run_chk("exit", 32'h100, 32'd11);
    trap_ack = 1'b0;
    step(); run_chk("post", 32'h104, 32'd12);
    trap_ack = 1'b1;
    step(); run_chk("ackRun", 32'h108, 32'd13);
    trap_ack = 1'b0;

    flags(0, 0, 1, 0, 32'h10, 32'd0);
    stall = 1'b1;
    step(); run_chk("stall1", 32'h108, 32'd13);
    step(); run_chk("stall2", 32'h108, 32'd13);
    stall = 1'b0;
    step(); run_chk("unstall", 32'h118, 32'd14);
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    step(); run_chk("once", 32'h11C, 32'd15);

    // jalr clears bit 0 but bit 1 still traps
    flags(0, 0, 0, 1, 32'd0, 32'h203);
    step(); trap_chk("trap2", 32'h11C, 32'h202, 32'd15);
    trap_ack = 1'b1;
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    step(); run_chk("exit2", 32'h100, 32'd15);
    trap_ack = 1'b0;

    // misaligned taken branch traps as well
    flags(1, 1, 0, 0, 32'h1, 32'd0);
    step(); trap_chk("trap3", 32'h100, 32'h101, 32'd15);
    trap_ack = 1'b1;
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    step(); run_chk("exit3", 32'h100, 32'd15);
    trap_ack = 1'b0;

    flags(0, 0, 0, 1, 32'd0, 32'hFFFF_FFFC);
    step(); run_chk("toTop", 32'hFFFF_FFFC, 32'd16);
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    step(); run_chk("wrap", 32'd0, 32'd17);

    flags(0, 0, 1, 0, 32'h2, 32'd0);
    step(); trap_chk("trap4", 32'd0, 32'h2, 32'd17);
    rst_n = 1'b0;
    #2;
    chk("arst.pc", pc, 32'd0);
    chk("arst.epc", epc, 32'd0);
    chk("arst.bad", bad_addr, 32'd0);
    chk("arst.ret", instret, 32'd0);
    chk("arst.fv", {31'd0, fetch_valid}, 32'd0);
    chk("arst.tv", {31'd0, trap_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    flags(0, 0, 0, 0, 32'd0, 32'd0);
    chk("reboot.pc", pc, 32'd0);
    step(); run_chk("rerun", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage downstream of `branch_unit`. It consumes `BranchTaken` together with the decoder's jump/branch flags, selects the next PC (sequential, branch, JAL, JALR), and holds it in a register that drives instruction fetch. It also detects misaligned control-transfer targets, redirects to a trap vector with an acknowledge handshake, and keeps a retired-instruction counter.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be 4-byte aligned.
- `TRAP_VEC`, default 32'h0000_0100: PC loaded on a misaligned-target trap. Must be 4-byte aligned.
- `clk`  input  1  clock. All state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  holds the PC and counter while in RUN.
- `branch`  input  1  current instruction is B-type.
- `BranchTaken`  input  1  comparison result from `branch_unit`.
- `jal`  input  1  current instruction is JAL.
- `jalr`  input  1  current instruction is JALR.
- `imm`  input  32  sign-extended immediate (B, J or I form, as selected by the decoder).
- `rs1`  input  32  register operand for JALR.
- `pc`  output  32  current PC (registered).
- `pc_plus4`  output  32  `pc + 4`, combinational. This is the link value for JAL/JALR.
- `fetch_valid`  output  1  high only in RUN. When high, `pc` is a legal fetch address.
- `trap_valid`  output  1  high in TRAP.
- `trap_ack`  input  1  trap handler acknowledge.
- `epc`  output  32  PC of the faulting instruction.
- `bad_addr`  output  32  the misaligned target that caused the trap.
- `instret`  output  32  count of retired instructions.

## Operation
- **FSM states: BOOT, RUN, TRAP.**
- **Reset (asynchronous).** Any low level on `rst_n`, including mid-trap, immediately forces:
  - state = BOOT
  - `pc` = RESET_PC
  - `epc` = 0, `bad_addr` = 0, `instret` = 0
  - `fetch_valid` = 0, `trap_valid` = 0
- **BOOT.** Lasts exactly one cycle, then goes to RUN unconditionally. `pc` is held and `stall` is ignored.
- **RUN, target selection.** Fixed priority:
  1. `jalr`: (`rs1` + `imm`) & ~32'h1
  2. `jal`: `pc` + `imm`
  3. `branch` && `BranchTaken`: `pc` + `imm`
  4. otherwise: `pc` + 4
- `BranchTaken` is ignored when `branch` = 0. If several flags are set together, the priority above decides.
- **Arithmetic.** All sums are 32-bit modulo, so wrap-around is silent and legal. For example, `pc` = 32'hFFFF_FFFC sequential gives 32'h0000_0000.
- **Misalignment.** A target is misaligned when target[1:0] != 2'b00 and the target came from a taken redirect (priorities 1–3). Sequential targets are always aligned and never trap.
- **RUN, `stall` = 1.** All state is held.
- **RUN, `stall` = 0, target aligned.**
  - `pc` <= target
  - `instret` <= `instret` + 1 (wraps at 2^32)
- **RUN, `stall` = 0, target misaligned.**
  - `epc` <= `pc`
  - `bad_addr` <= target
  - `pc` <= TRAP_VEC
  - state <= TRAP
  - `instret` is not incremented.
- **TRAP.**
  - `trap_valid` = 1 and `fetch_valid` = 0.
  - `pc`, `epc` and `bad_addr` are held, and `stall` is ignored.
  - When `trap_ack` = 1, the next state is RUN.
  - `trap_ack` outside TRAP is ignored.
- `epc` and `bad_addr` keep their values until the next trap overwrites them.

## Timing
- The next PC is visible one clock after the edge at which RUN sampled the inputs with `stall` = 0.
- `fetch_valid` first rises one cycle after `rst_n` deasserts, at the BOOT→RUN edge.
- Trap entry:
  - `trap_valid`, `epc` and `bad_addr` update on the same edge that loads TRAP_VEC.
  - `trap_valid` stays high for at least one cycle.
- Trap exit:
  - `trap_ack` sampled high in TRAP makes `trap_valid` = 0 and `fetch_valid` = 1 in the next cycle.
  - The first RUN cycle after the trap fetches TRAP_VEC.
- `pc_plus4` is combinational from `pc`; no other output has combinational paths from inputs.

## Structure
- Shared package/header holds:
  - state encodings `ST_BOOT` = 2'd0, `ST_RUN` = 2'd1, `ST_TRAP` = 2'd2
  - constant `PC_STEP` = 32'd4
- Sub-module `next_pc_sel` (combinational) produces the target and the misaligned flag. `pc_unit` holds the FSM and all registers.
- Elaboration-time check: RESET_PC[1:0] and TRAP_VEC[1:0] must both be 0.

## Test plan
1. **Reset and sequential fetch.**
   - Stimulus: release `rst_n`; no flags set, `stall` = 0.
   - Required: `pc` = 0 for the BOOT cycle and the first RUN cycle, then 4, 8, 12. `instret` increments once per RUN cycle.
2. **Branch taken vs. not taken.**
   - Stimulus: `pc` = 32'h20, `branch` = 1, `imm` = 32'hFFFF_FFF0.
   - Required: with `BranchTaken` = 1, `pc` becomes 32'h10. With `BranchTaken` = 0, `pc` becomes 32'h24.
   - Also: `branch` = 0 with `BranchTaken` = 1 gives 32'h24.
3. **JALR clears bit 0 and has priority.**
   - Stimulus: `rs1` = 32'h101, `imm` = 32'h4, `jalr` = `jal` = 1.
   - Required: `pc` = 32'h104, no trap.
4. **Misaligned-target trap.**
   - Stimulus: `pc` = 32'h40, `jal` = 1, `imm` = 32'h6.
   - Required next cycle: `pc` = 32'h100, `epc` = 32'h40, `bad_addr` = 32'h46, `trap_valid` = 1, `fetch_valid` = 0, `instret` unchanged.
   - Then: hold `trap_ack` = 0 for 3 cycles, and all values are held. Assert `trap_ack`: RUN resumes at 32'h100 and the following sequential step gives 32'h104.
5. **Stall behaviour.**
   - Stimulus: `stall` = 1 for 2 cycles with `jal` = 1.
   - Required: `pc` and `instret` are frozen. On release, the jump is taken once.
   - Also: `stall` during TRAP and BOOT has no effect.
6. **Wrap-around and reset mid-trap.**
   - Stimulus: `pc` = 32'hFFFF_FFFC, sequential step.
   - Required: `pc` = 0.
   - Also: pulse `rst_n` low while in TRAP, and all outputs return to their reset values asynchronously.
